// File: rtl/mem_access_ctrl_if.sv
// Bundle of pipeline request/response and data-memory port signals for mem_access_ctrl.
// Handshake: the pipeline raises req_valid and holds req_* stable while stall=1; completion is the one-cycle rsp_valid pulse.
interface mem_access_ctrl_if #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_SIZE = 11
);
   logic                   req_valid;
   logic                   req_write;
   logic                   req_double;
   logic [ADDR_SIZE-1:0]   req_addr;
   logic [2*WORD_SIZE-1:0] req_wdata;
   logic                   stall;
   logic                   rsp_valid;
   logic [2*WORD_SIZE-1:0] rsp_rdata;
   logic                   mem_read;
   logic                   mem_write;
   logic [ADDR_SIZE-1:0]   mem_addr;
   logic [WORD_SIZE-1:0]   mem_wd;
   logic [WORD_SIZE-1:0]   mem_rd;

   // master: pipeline plus data memory; slave: the access controller
   modport master (
      output req_valid, req_write, req_double, req_addr, req_wdata, mem_rd,
      input  stall, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wd
   );

   modport slave (
      input  req_valid, req_write, req_double, req_addr, req_wdata, mem_rd,
      output stall, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wd
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: sequences one single/double-word load or store into word accesses
// on a negedge-acting data memory, stalling the pipeline until the response pulse.
module mem_access_ctrl #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_SIZE = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_access_ctrl_if.slave     bus,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_e;

   state_e                 state_q, state_d;
   logic                   write_q, write_d;
   logic                   double_q, double_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [2*WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0]   word0_q, word0_d;
   logic                   mem_read_q, mem_read_d;
   logic                   mem_write_q, mem_write_d;
   logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [WORD_SIZE-1:0]   mem_wd_q, mem_wd_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [2*WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         double_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         word0_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wd_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         double_q    <= double_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         word0_q     <= word0_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wd_q    <= mem_wd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      double_d    = double_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      word0_d     = word0_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wd_d    = mem_wd_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (bus.req_valid) begin
               write_d     = bus.req_write;
               double_d    = bus.req_double;
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               mem_read_d  = !bus.req_write;
               mem_write_d = bus.req_write;
               mem_addr_d  = bus.req_addr;
               // Double stores send the high half first so it lands at the lower address
               mem_wd_d    = bus.req_double ? bus.req_wdata[2*WORD_SIZE-1:WORD_SIZE]
                                            : bus.req_wdata[WORD_SIZE-1:0];
               state_d     = ACC0;
            end
         end
         ACC0: begin
            if (!write_q) word0_d = bus.mem_rd;
            if (double_q) begin
               mem_addr_d = addr_q + ADDR_SIZE'(1);
               mem_wd_d   = wdata_q[WORD_SIZE-1:0];
               state_d    = ACC1;
            end else begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               rsp_valid_d = 1'b1;
               if (!write_q) rsp_rdata_d = {{WORD_SIZE{1'b0}}, bus.mem_rd};
               state_d     = DONE;
            end
         end
         ACC1: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            rsp_valid_d = 1'b1;
            if (!write_q) rsp_rdata_d = {word0_q, bus.mem_rd};
            state_d     = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // DONE deliberately drops stall so the pipeline advances in the same cycle as rsp_valid
   assign bus.stall     = ((state_q == IDLE) && bus.req_valid) || (state_q == ACC0) || (state_q == ACC1);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wd    = mem_wd_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: negedge data memory model, shadow-memory reference and latency/port checks.
module tb_mem_access_ctrl;
   localparam int W = 16;
   localparam int A = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   int         total = 0;
   int         bad = 0;

   logic [W-1:0]   mem    [0:(1<<A)-1];
   logic [W-1:0]   shadow [0:(1<<A)-1];
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_rdata;

   mem_access_ctrl_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus ();

   mem_access_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Data memory: acts on negedge, read has priority, cleared while rst is high
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1<<A); i++) mem[i] <= '0;
      end else if (bus.mem_read) begin
         bus.mem_rd <= mem[bus.mem_addr];
      end else if (bus.mem_write) begin
         mem[bus.mem_addr] <= bus.mem_wd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < (1<<A); i++) shadow[i] = '0;
      last_rdata = '0;
      exp_q.delete();
   endtask

   task automatic run_req(input bit wr, input bit dbl, input logic [A-1:0] addr,
                          input logic [2*W-1:0] wdata, input bit hold);
      logic [A-1:0]   a1;
      logic [2*W-1:0] exp, rdata;
      int n, lat, stall_cnt, wr_cnt, rd_cnt;
      bit got, both;
      a1 = addr + 11'd1;
      if (wr) begin
         if (dbl) begin
            shadow[addr] = wdata[2*W-1:W];
            shadow[a1]   = wdata[W-1:0];
         end else begin
            shadow[addr] = wdata[W-1:0];
         end
         exp = last_rdata;
      end else begin
         exp = dbl ? {shadow[addr], shadow[a1]} : {16'h0000, shadow[addr]};
         last_rdata = exp;
      end
      exp_q.push_back(exp);

      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_double = dbl;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      n = 0; lat = 0; stall_cnt = 0; wr_cnt = 0; rd_cnt = 0; got = 0; both = 0; rdata = '0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.stall) stall_cnt++;
         if (bus.mem_write) wr_cnt++;
         if (bus.mem_read) rd_cnt++;
         if (bus.mem_read && bus.mem_write) both = 1;
         if (bus.rsp_valid) begin
            got = 1;
            lat = n;
            rdata = bus.rsp_rdata;
         end
         if (n == 2) begin
            bus.req_write  = 1'($urandom_range(0, 1));
            bus.req_double = 1'($urandom_range(0, 1));
            bus.req_addr   = A'($urandom);
            bus.req_wdata  = $urandom;
         end
      end
      if (!got) chk("rsp_timeout", 32'd0, 32'd1);
      chk("latency", lat, dbl ? 4 : 3);
      chk("stall_cycles", stall_cnt, dbl ? 3 : 2);
      chk("write_cycles", wr_cnt, wr ? (dbl ? 2 : 1) : 0);
      chk("read_cycles", rd_cnt, wr ? 0 : (dbl ? 2 : 1));
      chk("rw_exclusive", {31'd0, both}, 32'd0);
      exp = exp_q.pop_front();
      if (got) chk("rsp_rdata", rdata, exp);
      if (wr) begin
         chk("mem_word0", {16'h0, mem[addr]}, {16'h0, shadow[addr]});
         if (dbl) chk("mem_word1", {16'h0, mem[a1]}, {16'h0, shadow[a1]});
      end
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int k);
      bus.req_valid = 1'b0;
      repeat (k) begin
         @(negedge clk);
         chk("idle_stall", {31'd0, bus.stall}, 32'd0);
         chk("idle_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      end
   endtask

   task automatic reset_mid_double_store();
      int pulses;
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_double = 1'b1;
      bus.req_addr   = 11'h040;
      bus.req_wdata  = 32'h5A5AA5A5;
      repeat (3) @(negedge clk);
      chk("pre_rst_acc1_stall", {31'd0, bus.stall}, 32'd1);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
      chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_model();
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid) pulses++;
      end
      chk("rst_no_rsp_pulse", pulses, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
   endtask

   initial begin
      logic [A-1:0] addr;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_double = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      clear_model();

      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall", {31'd0, bus.stall}, 32'd0);
      chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("reset_mem_read", {31'd0, bus.mem_read}, 32'd0);
      chk("reset_mem_write", {31'd0, bus.mem_write}, 32'd0);
      chk("reset_mem_addr", {21'd0, bus.mem_addr}, 32'd0);
      chk("reset_mem_wd", {16'd0, bus.mem_wd}, 32'd0);
      rst = 1'b0;

      run_req(1, 0, 11'h005, 32'hFFFF1234, 0);
      run_req(0, 0, 11'h005, 32'h0, 0);
      chk("single_load_value", last_rdata, 32'h00001234);

      run_req(1, 1, 11'h100, 32'hAABBCCDD, 0);
      chk("dbl_mem_100", {16'h0, mem[11'h100]}, 32'h0000AABB);
      chk("dbl_mem_101", {16'h0, mem[11'h101]}, 32'h0000CCDD);
      run_req(0, 1, 11'h100, 32'h0, 0);
      chk("dbl_load_value", last_rdata, 32'hAABBCCDD);

      run_req(1, 1, 11'h7FF, 32'h11112222, 0);
      chk("wrap_mem_7ff", {16'h0, mem[11'h7FF]}, 32'h00001111);
      chk("wrap_mem_000", {16'h0, mem[11'h000]}, 32'h00002222);
      run_req(0, 1, 11'h7FF, 32'h0, 0);
      idle_cycles(2);

      run_req(1, 0, 11'h010, 32'h0000BEEF, 1);
      run_req(1, 1, 11'h011, 32'hCAFEF00D, 1);
      run_req(0, 1, 11'h010, 32'h0, 1);
      run_req(0, 0, 11'h012, 32'h0, 0);
      idle_cycles(1);

      reset_mid_double_store();

      for (int i = 0; i < 40; i++) begin
         addr = ($urandom_range(0, 1) == 1) ? A'($urandom_range(0, 15))
                                            : A'($urandom_range(11'h7F0, 11'h7FF));
         run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
                 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
